// File: rtl/enemy_fire_scheduler_pkg.sv
// Shared definitions for the enemy fire scheduler: default formation size,
// cooldown defaults, output index width, FSM state encoding, shooter payload.
package enemy_fire_scheduler_pkg;

  localparam int unsigned LINHAS_DEF  = 4;
  localparam int unsigned COLUNAS_DEF = 10;
  localparam int unsigned CD_W_DEF    = 24;
  localparam int unsigned IDX_W       = 10;
  localparam int unsigned LEVEL_W     = 5;

  localparam logic [CD_W_DEF-1:0] COOLDOWN_BASE_DEF = 24'd6_000_000;
  localparam logic [CD_W_DEF-1:0] COOLDOWN_STEP_DEF = 24'd400_000;
  localparam logic [CD_W_DEF-1:0] COOLDOWN_MIN_DEF  = 24'd1_000_000;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_COOLDOWN = 2'd1,
    ST_SEARCH   = 2'd2,
    ST_REQUEST  = 2'd3
  } efs_state_e;

  // Shooter identity as seen by the top level (posX / posY lookup indices).
  typedef struct packed {
    logic [IDX_W-1:0] id_x;
    logic [IDX_W-1:0] id_y;
  } shooter_t;

endpackage

// File: rtl/enemy_fire_scheduler_if.sv
// Bundle between the scheduler and its environment.
//   enable, vivo_inimigo, level, shot_busy, fire_ready : into the scheduler
//   fire_valid, ID_enemy_tiro_X/Y, no_target           : out of the scheduler
// master = scheduler side, slave = game logic / projectile side.
interface enemy_fire_scheduler_if
  import enemy_fire_scheduler_pkg::*;
#(
  parameter int unsigned LINHAS  = LINHAS_DEF,
  parameter int unsigned COLUNAS = COLUNAS_DEF
);

  logic                      enable;
  logic [LINHAS*COLUNAS-1:0] vivo_inimigo;
  logic [LEVEL_W-1:0]        level;
  logic                      shot_busy;
  logic                      fire_ready;
  logic                      fire_valid;
  logic [IDX_W-1:0]          ID_enemy_tiro_X;
  logic [IDX_W-1:0]          ID_enemy_tiro_Y;
  logic                      no_target;

  modport master (
    input  enable, vivo_inimigo, level, shot_busy, fire_ready,
    output fire_valid, ID_enemy_tiro_X, ID_enemy_tiro_Y, no_target
  );

  modport slave (
    output enable, vivo_inimigo, level, shot_busy, fire_ready,
    input  fire_valid, ID_enemy_tiro_X, ID_enemy_tiro_Y, no_target
  );

endinterface

// File: rtl/enemy_fire_scheduler_column_bottom_finder.sv
// Priority encoder over one formation column: reports whether any invader in
// the column is alive and the highest (bottom-most) alive row.
//   col_alive : alive bits of the column, bit r = row r (row 0 at the top)
//   found_c   : at least one bit set
//   row_c     : highest set bit index (0 when nothing found)
module column_bottom_finder #(
  parameter int unsigned LINHAS = 4,
  parameter int unsigned ROW_W  = 2
) (
  input  logic [LINHAS-1:0] col_alive,
  output logic              found_c,
  output logic [ROW_W-1:0]  row_c
);

  // Ascending scan: the last hit wins, giving the bottom-most row.
  always_comb begin
    found_c = 1'b0;
    row_c   = '0;
    for (int r = 0; r < LINHAS; r++) begin
      if (col_alive[r]) begin
        found_c = 1'b1;
        row_c   = ROW_W'(r);
      end
    end
  end

endmodule

// File: rtl/enemy_fire_scheduler.sv
// Picks the next invader to fire: waits a level-dependent cooldown, walks the
// formation columns round-robin for the bottom-most live invader, and offers
// it to the projectile unit over a valid/ready handshake.
//   clk, reset : clock, synchronous active-low reset
//   if_p       : scheduler side of enemy_fire_scheduler_if (see interface)
module enemy_fire_scheduler
  import enemy_fire_scheduler_pkg::*;
#(
  parameter int unsigned        LINHAS        = LINHAS_DEF,
  parameter int unsigned        COLUNAS       = COLUNAS_DEF,
  parameter int unsigned        CD_W          = CD_W_DEF,
  parameter logic [CD_W-1:0]    COOLDOWN_BASE = COOLDOWN_BASE_DEF,
  parameter logic [CD_W-1:0]    COOLDOWN_STEP = COOLDOWN_STEP_DEF,
  parameter logic [CD_W-1:0]    COOLDOWN_MIN  = COOLDOWN_MIN_DEF
) (
  input logic                     clk,
  input logic                     reset,
  enemy_fire_scheduler_if.master  if_p
);

  localparam int unsigned PTR_W  = (COLUNAS > 1) ? $clog2(COLUNAS) : 1;
  localparam int unsigned ROW_W  = (LINHAS > 1) ? $clog2(LINHAS) : 1;
  localparam int unsigned SCAN_W = $clog2(COLUNAS + 1);
  localparam int unsigned VIDX_W = $clog2(LINHAS * COLUNAS);
  localparam int unsigned PW     = CD_W + 5;

  efs_state_e        state_q, state_d;
  logic [PTR_W-1:0]  ptr_q, ptr_d;
  logic [CD_W-1:0]   cnt_q, cnt_d;
  logic [SCAN_W-1:0] scan_q, scan_d;
  shooter_t          shooter_q, shooter_d;
  logic              no_target_q, no_target_d;
  logic              fire_valid_q, fire_valid_d;

  logic [LINHAS-1:0] col_bits;
  logic [VIDX_W-1:0] vidx;
  logic              finder_found;
  logic [ROW_W-1:0]  finder_row;
  logic              shooter_alive;
  logic [PTR_W-1:0]  ptr_next;
  logic [PW-1:0]     prod, base_w, min_w, diff;
  logic [CD_W-1:0]   cd_val;

  // Alive bits of the column under the pointer.
  always_comb begin
    col_bits = '0;
    vidx     = '0;
    for (int r = 0; r < LINHAS; r++) begin
      vidx        = VIDX_W'(r * COLUNAS) + VIDX_W'(ptr_q);
      col_bits[r] = if_p.vivo_inimigo[vidx];
    end
  end

  column_bottom_finder #(
    .LINHAS (LINHAS),
    .ROW_W  (ROW_W)
  ) u_finder (
    .col_alive (col_bits),
    .found_c   (finder_found),
    .row_c     (finder_row)
  );

  // ptr still points at the shooter's column while requesting.
  assign shooter_alive = col_bits[ROW_W'(shooter_q.id_y)];
  assign ptr_next      = (ptr_q == PTR_W'(COLUNAS - 1)) ? '0 : ptr_q + PTR_W'(1);

  // Cooldown for the current level, floored at COOLDOWN_MIN; an underflow of
  // the subtraction is treated as below the floor.
  always_comb begin
    prod   = PW'(if_p.level) * PW'(COOLDOWN_STEP);
    base_w = PW'(COOLDOWN_BASE);
    min_w  = PW'(COOLDOWN_MIN);
    diff   = base_w - prod;
    if ((prod > base_w) || (diff < min_w)) begin
      cd_val = COOLDOWN_MIN;
    end else begin
      cd_val = CD_W'(diff);
    end
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    cnt_d        = cnt_q;
    scan_d       = scan_q;
    shooter_d    = shooter_q;
    no_target_d  = no_target_q;
    fire_valid_d = 1'b0;

    if (!if_p.enable) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_COOLDOWN;
          cnt_d   = cd_val;
        end
        ST_COOLDOWN: begin
          if (cnt_q == '0) begin
            state_d = ST_SEARCH;
            scan_d  = '0;
          end else if (!if_p.shot_busy) begin
            cnt_d = cnt_q - CD_W'(1);
          end
        end
        ST_SEARCH: begin
          if (finder_found) begin
            shooter_d.id_x = IDX_W'(finder_row) * IDX_W'(COLUNAS) + IDX_W'(ptr_q);
            shooter_d.id_y = IDX_W'(finder_row);
            no_target_d    = 1'b0;
            fire_valid_d   = 1'b1;
            state_d        = ST_REQUEST;
          end else begin
            ptr_d  = ptr_next;
            scan_d = scan_q + SCAN_W'(1);
            if (scan_q == SCAN_W'(COLUNAS - 1)) begin
              no_target_d = 1'b1;
              state_d     = ST_COOLDOWN;
              cnt_d       = cd_val;
            end
          end
        end
        ST_REQUEST: begin
          if (!shooter_alive) begin
            // Shooter died before launch: rescan the same column.
            state_d = ST_SEARCH;
            scan_d  = '0;
          end else if (if_p.fire_ready) begin
            ptr_d   = ptr_next;
            state_d = ST_COOLDOWN;
            cnt_d   = cd_val;
          end else begin
            fire_valid_d = 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      ptr_q        <= '0;
      cnt_q        <= '0;
      scan_q       <= '0;
      shooter_q    <= '0;
      no_target_q  <= 1'b0;
      fire_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      cnt_q        <= cnt_d;
      scan_q       <= scan_d;
      shooter_q    <= shooter_d;
      no_target_q  <= no_target_d;
      fire_valid_q <= fire_valid_d;
    end
  end

  assign if_p.fire_valid      = fire_valid_q;
  assign if_p.ID_enemy_tiro_X = shooter_q.id_x;
  assign if_p.ID_enemy_tiro_Y = shooter_q.id_y;
  assign if_p.no_target       = no_target_q;

endmodule
